// File: rtl/pi_by_2_bpsk_seq.sv
// Frame sequencer for the pi/2-BPSK mapper: loads one word at a time onto the
// mapper input and streams its per-bit I/Q outputs as one registered symbol per cycle.
module pi_by_2_bpsk_seq #(
    parameter int DATA_WIDTH        = 16,
    parameter int SYM_WIDTH         = 16,
    parameter int FRAME_WORDS_WIDTH = 8,
    parameter int IDX_WIDTH         = FRAME_WORDS_WIDTH + $clog2(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [FRAME_WORDS_WIDTH-1:0]  cfg_num_words,
    output logic                          busy,
    output logic                          done,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         map_data,
    output logic                          map_enable,
    input  logic signed [SYM_WIDTH-1:0]   map_i [0:DATA_WIDTH-1],
    input  logic signed [SYM_WIDTH-1:0]   map_q [0:DATA_WIDTH-1],
    output logic signed [SYM_WIDTH-1:0]   out_i,
    output logic signed [SYM_WIDTH-1:0]   out_q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [IDX_WIDTH-1:0]          out_sym_idx
);

    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_PRIME  = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [FRAME_WORDS_WIDTH-1:0]   words_left_q, words_left_d;
    logic [BW-1:0]                  idx_q, idx_d;
    logic [BW-1:0]                  idx_inc;
    logic [IDX_WIDTH-1:0]           sym_idx_q, sym_idx_d;
    logic [DATA_WIDTH-1:0]          map_data_q, map_data_d;
    logic signed [SYM_WIDTH-1:0]    out_i_q, out_i_d;
    logic signed [SYM_WIDTH-1:0]    out_q_q, out_q_d;
    logic                           out_valid_q, out_valid_d;
    logic                           done_q, done_d;
    logic                           last_bit;
    logic                           last_word;
    logic                           out_hs;

    assign idx_inc   = idx_q + BW'(1);
    assign last_bit  = (idx_q == LAST_BIT);
    assign last_word = (words_left_q == FRAME_WORDS_WIDTH'(1));
    assign out_hs    = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            idx_q        <= '0;
            sym_idx_q    <= '0;
            map_data_q   <= '0;
            out_i_q      <= '0;
            out_q_q      <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            idx_q        <= idx_d;
            sym_idx_q    <= sym_idx_d;
            map_data_q   <= map_data_d;
            out_i_q      <= out_i_d;
            out_q_q      <= out_q_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        idx_d        = idx_q;
        sym_idx_d    = sym_idx_q;
        map_data_d   = map_data_q;
        out_i_d      = out_i_q;
        out_q_d      = out_q_q;
        out_valid_d  = out_valid_q;
        done_d       = 1'b0;

        if (abort) begin
            // map_data and the symbol registers are deliberately left untouched
            state_d      = S_IDLE;
            words_left_d = '0;
            idx_d        = '0;
            sym_idx_d    = '0;
            out_valid_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_num_words != '0) begin
                            words_left_d = cfg_num_words;
                            sym_idx_d    = '0;
                            state_d      = S_LOAD;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        map_data_d = in_data;
                        idx_d      = '0;
                        state_d    = S_PRIME;
                    end
                end
                S_PRIME: begin
                    out_i_d     = map_i[0];
                    out_q_d     = map_q[0];
                    out_valid_d = 1'b1;
                    state_d     = S_STREAM;
                end
                S_STREAM: begin
                    if (out_hs) begin
                        if (!last_bit) begin
                            out_i_d   = map_i[idx_inc];
                            out_q_d   = map_q[idx_inc];
                            idx_d     = idx_inc;
                            sym_idx_d = sym_idx_q + IDX_WIDTH'(1);
                        end else if (!last_word) begin
                            words_left_d = words_left_q - FRAME_WORDS_WIDTH'(1);
                            sym_idx_d    = sym_idx_q + IDX_WIDTH'(1);
                            out_valid_d  = 1'b0;
                            state_d      = S_LOAD;
                        end else begin
                            out_valid_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // in_ready is masked by abort so a word offered in the abort cycle is never consumed
    assign in_ready    = (state_q == S_LOAD) && !abort;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign map_data    = map_data_q;
    assign map_enable  = (state_q == S_PRIME) || (state_q == S_STREAM);
    assign out_i       = out_i_q;
    assign out_q       = out_q_q;
    assign out_valid   = out_valid_q;
    assign out_last    = (state_q == S_STREAM) && last_word && last_bit;
    assign out_sym_idx = sym_idx_q;

endmodule

// File: tb/tb_pi_by_2_bpsk_seq.sv
// Directed bench for pi_by_2_bpsk_seq with a behavioural pi/2-BPSK mapper (amplitude 0x5A82).
module tb_pi_by_2_bpsk_seq;

    localparam int DW  = 16;
    localparam int SW  = 16;
    localparam int FW  = 8;
    localparam int IW  = FW + $clog2(DW);
    localparam logic signed [SW-1:0] POS = 16'sh5A82;
    localparam logic signed [SW-1:0] NEG = 16'shA57E;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  abort;
    logic [FW-1:0]         cfg_num_words;
    logic                  busy;
    logic                  done;
    logic [DW-1:0]         in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         map_data;
    logic                  map_enable;
    logic signed [SW-1:0]  map_i [0:DW-1];
    logic signed [SW-1:0]  map_q [0:DW-1];
    logic signed [SW-1:0]  out_i;
    logic signed [SW-1:0]  out_q;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [IW-1:0]         out_sym_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pi_by_2_bpsk_seq #(
        .DATA_WIDTH        (DW),
        .SYM_WIDTH         (SW),
        .FRAME_WORDS_WIDTH (FW),
        .IDX_WIDTH         (IW)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_num_words (cfg_num_words),
        .busy          (busy),
        .done          (done),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .map_data      (map_data),
        .map_enable    (map_enable),
        .map_i         (map_i),
        .map_q         (map_q),
        .out_i         (out_i),
        .out_q         (out_q),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .out_sym_idx   (out_sym_idx)
    );

    // Mapper: bit 0 -> +A, bit 1 -> -A; odd symbols rotated by pi/2 (I negated)
    for (genvar k = 0; k < DW; k++) begin : g_map
        assign map_q[k] = !map_enable ? '0 : (map_data[k] ? NEG : POS);
        assign map_i[k] = !map_enable ? '0 :
                          ((map_data[k] ^ (k % 2 == 1)) ? NEG : POS);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_i(input logic b, input int k);
        if (!b) return (k % 2 == 0) ? 16'h5A82 : 16'hA57E;
        else    return (k % 2 == 0) ? 16'hA57E : 16'h5A82;
    endfunction

    function automatic logic [15:0] exp_q(input logic b);
        return b ? 16'hA57E : 16'h5A82;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int nw, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input bit tog, input int dly,
                             input int abort_at);
        logic [15:0] wds [0:2];
        logic [15:0] w;
        logic        b;
        int total, exp_sym, wptr, dcnt, done_cnt, cyc, acc_cyc, last_hs, k;
        bit phase, fin, aborted, first_seen;
        wds[0] = w0; wds[1] = w1; wds[2] = w2;
        total = nw * DW; exp_sym = 0; wptr = 0; dcnt = 0; done_cnt = 0; cyc = 0;
        acc_cyc = -100; last_hs = -100; phase = 1'b0; fin = 1'b0; aborted = 1'b0;
        first_seen = 1'b0;

        start = 1'b1; cfg_num_words = FW'(nw);
        step();
        start = 1'b0; cfg_num_words = '0;
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, 1);

        for (int c = 0; c < 2000 && !fin; c++) begin
            if (aborted) begin
                check("abort_out_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                fin = 1'b1;
            end else begin
                if (out_valid) begin
                    w = wds[exp_sym / DW];
                    k = exp_sym % DW;
                    b = w[k[3:0]];
                    check("sym_idx", 32'(out_sym_idx), exp_sym);
                    check("out_i", $unsigned(out_i), exp_i(b, k));
                    check("out_q", $unsigned(out_q), exp_q(b));
                    check("out_last", out_last, (exp_sym == total - 1) ? 1 : 0);
                    if (k == 0 && !first_seen) begin
                        check("sym0_latency", cyc - acc_cyc, 2);
                        first_seen = 1'b1;
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_after_last_hs", cyc - last_hs, 1);
                    check("busy_at_done", busy, 0);
                    check("sym_count", exp_sym, total);
                    fin = 1'b1;
                end
            end
            if (fin) break;

            abort = 1'b0;
            start = busy && (exp_sym == 3);
            cfg_num_words = start ? 8'd9 : 8'd0;
            if (in_ready && wptr < nw) begin
                if (dcnt < dly) begin
                    in_valid = 1'b0;
                    dcnt++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = wds[wptr];
                end
            end else begin
                in_valid = 1'b0;
            end
            out_ready = tog ? phase : 1'b1;
            phase = !phase;
            if (abort_at >= 0 && out_valid && exp_sym == abort_at) begin
                abort = 1'b1;
                out_ready = 1'b1;
            end
            #1;
            if (abort) begin
                aborted = 1'b1;
            end else begin
                if (in_valid && in_ready) begin
                    acc_cyc = cyc; wptr++; dcnt = 0; first_seen = 1'b0;
                end
                if (out_valid && out_ready) begin
                    last_hs = cyc; exp_sym++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("frame_finished", fin, 1);
        abort = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done) done_cnt++;
        end
        check("done_pulses", done_cnt, (abort_at >= 0) ? 0 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_num_words = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        #23;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_map_enable", map_enable, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_map_data", map_data, 0);
        check("rst_out_i", $unsigned(out_i), 0);
        check("rst_out_q", $unsigned(out_q), 0);
        check("rst_sym_idx", 32'(out_sym_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_frame(1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, -1);
        run_frame(1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 0, -1);
        run_frame(3, 16'h1234, 16'hA5C3, 16'h0F0F, 1'b1, 4, -1);

        start = 1'b1; cfg_num_words = '0;
        step();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_in_ready", in_ready, 0);
        step();
        check("zero_done_clear", done, 0);
        check("zero_in_ready2", in_ready, 0);

        run_frame(3, 16'h5555, 16'h9C31, 16'h00FF, 1'b0, 0, DW + 5);
        run_frame(1, 16'h8001, 16'h0000, 16'h0000, 1'b0, 0, -1);

        start = 1'b1; cfg_num_words = 8'd2;
        step();
        start = 1'b0; in_data = 16'hBEEF; in_valid = 1'b1; out_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            in_valid = 1'b0;
            seen = out_valid;
        end
        check("pre_reset_valid", seen, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_map_enable", map_enable, 0);
        check("arst_map_data", map_data, 0);
        check("arst_out_i", $unsigned(out_i), 0);
        check("arst_out_q", $unsigned(out_q), 0);
        check("arst_sym_idx", 32'(out_sym_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_reset_busy", busy, 0);
        check("post_reset_valid", out_valid, 0);

        run_frame(1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
